// File: rtl/cache_mem_arbiter_pkg.sv
// cache_pkg: shared constants and types for the cache/memory arbiter.
//   RD_TYPE_LINE / RD_TYPE_WORD : read request type codes issued by the caches
//   LINE_OFFSET_W               : byte-offset bits below the line address
//   rd_state_t / wr_state_t     : read and write FSM states
//   req_owner_t                 : which cache owns the read port
package cache_pkg;

  localparam logic [2:0] RD_TYPE_LINE  = 3'b100;
  localparam logic [2:0] RD_TYPE_WORD  = 3'b010;
  localparam int         LINE_OFFSET_W = 4;

  typedef enum logic {
    R_IDLE,
    R_WAIT_RET
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    OWN_IC,
    OWN_DC
  } req_owner_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: every bus between the two caches, the arbiter and the
// memory bridge.
//   slave  : arbiter view (takes cache requests and memory responses)
//   master : environment view (drives caches and memory)
//
// Handshake rules used on every channel:
//   *_req / *_valid is held by the source until accepted; a transfer happens
//   in the cycle where req and rdy are both 1. Return beats (*_ret_valid)
//   and write completions (mem_wr_bvalid) have no back-pressure and are
//   consumed in the cycle they are presented.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  // icache read side
  logic              ic_rd_req;
  logic [2:0]        ic_rd_type;
  logic [ADDR_W-1:0] ic_rd_addr;
  logic              ic_rd_rdy;
  logic              ic_ret_valid;
  logic              ic_ret_last;
  logic [31:0]       ic_ret_data;
  // dcache read side
  logic              dc_rd_req;
  logic [2:0]        dc_rd_type;
  logic [ADDR_W-1:0] dc_rd_addr;
  logic              dc_rd_rdy;
  logic              dc_ret_valid;
  logic              dc_ret_last;
  logic [31:0]       dc_ret_data;
  // dcache write-back
  logic              dc_wr_req;
  logic [2:0]        dc_wr_type;
  logic [ADDR_W-1:0] dc_wr_addr;
  logic [3:0]        dc_wr_wstrb;
  logic [127:0]      dc_wr_data;
  logic              dc_wr_rdy;
  // memory read
  logic              mem_rd_req;
  logic [2:0]        mem_rd_type;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_rdy;
  logic              mem_ret_valid;
  logic              mem_ret_last;
  logic [31:0]       mem_ret_data;
  // memory write
  logic              mem_wr_req;
  logic [2:0]        mem_wr_type;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [3:0]        mem_wr_wstrb;
  logic [127:0]      mem_wr_data;
  logic              mem_wr_rdy;
  logic              mem_wr_bvalid;

  modport slave (
    input  ic_rd_req, ic_rd_type, ic_rd_addr,
    output ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
    input  dc_rd_req, dc_rd_type, dc_rd_addr,
    output dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data,
    input  dc_wr_req, dc_wr_type, dc_wr_addr, dc_wr_wstrb, dc_wr_data,
    output dc_wr_rdy,
    output mem_rd_req, mem_rd_type, mem_rd_addr,
    input  mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data,
    output mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data,
    input  mem_wr_rdy, mem_wr_bvalid
  );

  modport master (
    output ic_rd_req, ic_rd_type, ic_rd_addr,
    input  ic_rd_rdy, ic_ret_valid, ic_ret_last, ic_ret_data,
    output dc_rd_req, dc_rd_type, dc_rd_addr,
    input  dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_ret_data,
    output dc_wr_req, dc_wr_type, dc_wr_addr, dc_wr_wstrb, dc_wr_data,
    input  dc_wr_rdy,
    input  mem_rd_req, mem_rd_type, mem_rd_addr,
    output mem_rd_rdy, mem_ret_valid, mem_ret_last, mem_ret_data,
    input  mem_wr_req, mem_wr_type, mem_wr_addr, mem_wr_wstrb, mem_wr_data,
    output mem_wr_rdy, mem_wr_bvalid
  );

endinterface

// File: rtl/cache_mem_arbiter_wb_buffer.sv
// wb_buffer: one-entry dcache write-back buffer and its write FSM.
//   clk, rst_n         : clock, asynchronous active-low reset
//   wr_req/type/addr/wstrb/data, wr_rdy : write-back from the dcache
//   mem_wr_req/type/addr/wstrb/data, mem_wr_rdy, mem_wr_bvalid : memory write
//   busy, line_addr    : buffer occupancy and held line for the read hazard check
//   state_dbg          : current write FSM state
module wb_buffer
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_req,
  input  logic [2:0]                      wr_type,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [3:0]                      wr_wstrb,
  input  logic [127:0]                    wr_data,
  output logic                            wr_rdy,
  input  logic                            mem_wr_rdy,
  input  logic                            mem_wr_bvalid,
  output logic                            mem_wr_req,
  output logic [2:0]                      mem_wr_type,
  output logic [ADDR_W-1:0]               mem_wr_addr,
  output logic [3:0]                      mem_wr_wstrb,
  output logic [127:0]                    mem_wr_data,
  output logic                            busy,
  output logic [ADDR_W-1:LINE_OFFSET_W]   line_addr,
  output wr_state_t                       state_dbg
);

  wr_state_t         state, state_next;
  logic [2:0]        wbuf_type;
  logic [ADDR_W-1:0] wbuf_addr;
  logic [3:0]        wbuf_wstrb;
  logic [127:0]      wbuf_data;
  logic              capture;

  // wr_rdy is the dcache's go-ahead, so it is high in W_IDLE whether or not
  // a write-back is currently offered.
  assign wr_rdy  = (state == W_IDLE);
  assign capture = wr_req && wr_rdy;

  always_comb begin
    state_next = state;
    case (state)
      W_IDLE: if (capture)       state_next = W_REQ;
      W_REQ:  if (mem_wr_rdy)    state_next = W_RESP;
      W_RESP: if (mem_wr_bvalid) state_next = W_IDLE;
      default:                   state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= W_IDLE;
      wbuf_type  <= '0;
      wbuf_addr  <= '0;
      wbuf_wstrb <= '0;
      wbuf_data  <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        wbuf_type  <= wr_type;
        wbuf_addr  <= wr_addr;
        wbuf_wstrb <= wr_wstrb;
        wbuf_data  <= wr_data;
      end
    end
  end

  assign mem_wr_req   = (state == W_REQ);
  assign mem_wr_type  = wbuf_type;
  assign mem_wr_addr  = wbuf_addr;
  assign mem_wr_wstrb = wbuf_wstrb;
  assign mem_wr_data  = wbuf_data;

  // The entry stays live until memory confirms the write, so refills of
  // this line are held off through both W_REQ and W_RESP.
  assign busy      = (state == W_REQ) || (state == W_RESP);
  assign line_addr = wbuf_addr[ADDR_W-1:LINE_OFFSET_W];
  assign state_dbg = state;

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory port between the icache and dcache.
// Line refills are arbitrated round-robin with one read outstanding; return
// beats are steered to the owning cache; dcache write-backs go through a
// one-entry buffer and block reads of the same line until they complete.
//   clk_g, resetn : clock, asynchronous active-low reset
//   bus           : all cache and memory channels (cache_mem_arbiter_if.slave)
//   rd_state_dbg  : read FSM state
//   wr_state_dbg  : write FSM state
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int LINE_BEATS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                   clk_g,
  input  logic                   resetn,
  cache_mem_arbiter_if.slave     bus,
  output rd_state_t              rd_state_dbg,
  output wr_state_t              wr_state_dbg
);

  localparam int CNT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

  rd_state_t         rd_state, rd_next;
  req_owner_t        owner_q, rr_last, grant;
  logic              grant_valid, rd_hs, ret_beat;
  logic [2:0]        type_q;
  logic [CNT_W-1:0]  beat_cnt;

  logic                          wbuf_busy, wr_rdy;
  logic [ADDR_W-1:LINE_OFFSET_W] wbuf_line;
  logic                          ic_hazard, dc_hazard, ic_elig, dc_elig;

  wb_buffer #(.ADDR_W(ADDR_W)) u_wb_buffer (
    .clk           (clk_g),
    .rst_n         (resetn),
    .wr_req        (bus.dc_wr_req),
    .wr_type       (bus.dc_wr_type),
    .wr_addr       (bus.dc_wr_addr),
    .wr_wstrb      (bus.dc_wr_wstrb),
    .wr_data       (bus.dc_wr_data),
    .wr_rdy        (wr_rdy),
    .mem_wr_rdy    (bus.mem_wr_rdy),
    .mem_wr_bvalid (bus.mem_wr_bvalid),
    .mem_wr_req    (bus.mem_wr_req),
    .mem_wr_type   (bus.mem_wr_type),
    .mem_wr_addr   (bus.mem_wr_addr),
    .mem_wr_wstrb  (bus.mem_wr_wstrb),
    .mem_wr_data   (bus.mem_wr_data),
    .busy          (wbuf_busy),
    .line_addr     (wbuf_line),
    .state_dbg     (wr_state_dbg)
  );

  assign bus.dc_wr_rdy = wr_rdy;

  // A read may not refill a line that is sitting in the write buffer. The
  // write being accepted this very cycle is also compared, because the
  // registered busy flag only rises on the next edge.
  always_comb begin
    ic_hazard = (wbuf_busy && (bus.ic_rd_addr[ADDR_W-1:LINE_OFFSET_W] == wbuf_line)) ||
                (bus.dc_wr_req && wr_rdy &&
                 (bus.ic_rd_addr[ADDR_W-1:LINE_OFFSET_W] == bus.dc_wr_addr[ADDR_W-1:LINE_OFFSET_W]));
    dc_hazard = (wbuf_busy && (bus.dc_rd_addr[ADDR_W-1:LINE_OFFSET_W] == wbuf_line)) ||
                (bus.dc_wr_req && wr_rdy &&
                 (bus.dc_rd_addr[ADDR_W-1:LINE_OFFSET_W] == bus.dc_wr_addr[ADDR_W-1:LINE_OFFSET_W]));
    ic_elig   = bus.ic_rd_req && !ic_hazard;
    dc_elig   = bus.dc_rd_req && !dc_hazard;
  end

  // Grant is combinational in R_IDLE; on a tie the cache that did not win
  // last time goes first.
  always_comb begin
    grant_valid = 1'b0;
    grant       = OWN_IC;
    if (rd_state == R_IDLE) begin
      if (ic_elig && dc_elig) begin
        grant_valid = 1'b1;
        grant       = (rr_last == OWN_IC) ? OWN_DC : OWN_IC;
      end else if (ic_elig) begin
        grant_valid = 1'b1;
        grant       = OWN_IC;
      end else if (dc_elig) begin
        grant_valid = 1'b1;
        grant       = OWN_DC;
      end
    end
  end

  assign rd_hs    = grant_valid && bus.mem_rd_rdy;
  assign ret_beat = (rd_state == R_WAIT_RET) && bus.mem_ret_valid;

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:     if (rd_hs)                       rd_next = R_WAIT_RET;
      R_WAIT_RET: if (ret_beat && bus.mem_ret_last) rd_next = R_IDLE;
      default:                                     rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_g or negedge resetn) begin
    if (!resetn) begin
      rd_state <= R_IDLE;
      owner_q  <= OWN_IC;
      rr_last  <= OWN_IC;
      type_q   <= '0;
      beat_cnt <= '0;
    end else begin
      rd_state <= rd_next;
      if (rd_hs) begin
        owner_q  <= grant;
        rr_last  <= grant;
        type_q   <= (grant == OWN_DC) ? bus.dc_rd_type : bus.ic_rd_type;
        beat_cnt <= '0;
      end else if (ret_beat) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // Request mirror and per-cache handshake.
  always_comb begin
    bus.mem_rd_req  = grant_valid;
    bus.mem_rd_type = '0;
    bus.mem_rd_addr = '0;
    if (grant_valid) begin
      bus.mem_rd_type = (grant == OWN_DC) ? bus.dc_rd_type : bus.ic_rd_type;
      bus.mem_rd_addr = (grant == OWN_DC) ? bus.dc_rd_addr : bus.ic_rd_addr;
    end
    bus.ic_rd_rdy = grant_valid && (grant == OWN_IC) && bus.mem_rd_rdy;
    bus.dc_rd_rdy = grant_valid && (grant == OWN_DC) && bus.mem_rd_rdy;
  end

  // Return beats pass straight through to the owner; data is zeroed when
  // not valid so an idle cache sees a quiet bus.
  always_comb begin
    bus.ic_ret_valid = ret_beat && (owner_q == OWN_IC);
    bus.dc_ret_valid = ret_beat && (owner_q == OWN_DC);
    bus.ic_ret_last  = bus.ic_ret_valid && bus.mem_ret_last;
    bus.dc_ret_last  = bus.dc_ret_valid && bus.mem_ret_last;
    bus.ic_ret_data  = bus.ic_ret_valid ? bus.mem_ret_data : 32'h0;
    bus.dc_ret_data  = bus.dc_ret_valid ? bus.mem_ret_data : 32'h0;
  end

  assign rd_state_dbg = rd_state;

  // A full-line refill must end exactly on its final beat.
  property p_last_on_final_beat;
    @(posedge clk_g) disable iff (!resetn)
      (ret_beat && bus.mem_ret_last && (type_q == RD_TYPE_LINE))
        |-> (beat_cnt == CNT_W'(LINE_BEATS - 1));
  endproperty
  a_last_on_final_beat: assert property (p_last_on_final_beat);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
  import cache_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk_g = 1'b0;
  logic resetn;
  always #5 clk_g = ~clk_g;

  cache_mem_arbiter_if #(.ADDR_W(32)) bus ();
  rd_state_t rd_state_dbg;
  wr_state_t wr_state_dbg;

  cache_mem_arbiter #(.LINE_BEATS(4), .ADDR_W(32)) dut (
    .clk_g        (clk_g),
    .resetn       (resetn),
    .bus          (bus),
    .rd_state_dbg (rd_state_dbg),
    .wr_state_dbg (wr_state_dbg)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [35:0]  rd_exp_q[$];  // {owner_is_dc, type, addr}
  logic [32:0]  ic_exp_q[$];  // {last, data}
  logic [32:0]  dc_exp_q[$];
  logic [163:0] wr_exp_q[$];  // {addr, wstrb, data}

  task automatic check(input string name, input logic [163:0] act, input logic [163:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_check33(input string name, inout logic [32:0] q[$], input logic [32:0] act);
    if (q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: unexpected beat %0h", name, act);
    end else begin
      check(name, {131'b0, act}, {131'b0, q.pop_front()});
    end
  endtask

  // Monitor: compares every DUT output event against the expected queues.
  always @(negedge clk_g) begin
    if (resetn === 1'b1) begin
      if (bus.ic_ret_valid) pop_check33("ic_ret", ic_exp_q, {bus.ic_ret_last, bus.ic_ret_data});
      if (bus.dc_ret_valid) pop_check33("dc_ret", dc_exp_q, {bus.dc_ret_last, bus.dc_ret_data});
      if (bus.mem_rd_req && bus.mem_rd_rdy) begin
        if (rd_exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL mem_rd: unexpected request addr %0h", bus.mem_rd_addr);
        end else begin
          check("mem_rd", {128'b0, bus.dc_rd_rdy, bus.mem_rd_type, bus.mem_rd_addr},
                {128'b0, rd_exp_q.pop_front()});
        end
      end
      if (bus.mem_wr_req && bus.mem_wr_rdy) begin
        if (wr_exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL mem_wr: unexpected write addr %0h", bus.mem_wr_addr);
        end else begin
          check("mem_wr", {bus.mem_wr_addr, bus.mem_wr_wstrb, bus.mem_wr_data}, wr_exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_g);
    #1;
  endtask

  // Waits (bounded) for a memory read handshake; returns which cache won,
  // the address seen by memory and how many cycles it took.
  task automatic wait_rd_hs(output logic ok, output logic is_dc, output logic [31:0] addr,
                            output int waited);
    ok = 1'b0; is_dc = 1'b0; addr = '0; waited = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_g);
      if (bus.mem_rd_req && bus.mem_rd_rdy) begin
        ok = 1'b1; is_dc = bus.dc_rd_rdy; addr = bus.mem_rd_addr; waited = i;
        break;
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL rd_handshake_timeout: got none expected handshake within 50 cycles");
    end
    step();
  endtask

  task automatic send_beats(input logic [31:0] base, input int n, input logic last_on_end,
                            input int bv_at);
    for (int b = 0; b < n; b++) begin
      bus.mem_ret_valid = 1'b1;
      bus.mem_ret_last  = last_on_end && (b == n - 1);
      bus.mem_ret_data  = base + 32'(b);
      bus.mem_wr_bvalid = (b == bv_at);
      step();
    end
    bus.mem_ret_valid = 1'b0;
    bus.mem_ret_last  = 1'b0;
    bus.mem_ret_data  = '0;
    bus.mem_wr_bvalid = 1'b0;
  endtask

  task automatic push_line(input logic is_dc, input logic [31:0] base);
    for (int b = 0; b < 4; b++) begin
      if (is_dc) dc_exp_q.push_back({b == 3, base + 32'(b)});
      else       ic_exp_q.push_back({b == 3, base + 32'(b)});
    end
  endtask

  task automatic start_write(input logic [31:0] addr, input logic [127:0] data);
    bus.dc_wr_req   = 1'b1;
    bus.dc_wr_type  = RD_TYPE_LINE;
    bus.dc_wr_addr  = addr;
    bus.dc_wr_wstrb = 4'hF;
    bus.dc_wr_data  = data;
  endtask

  // From W_RESP: hold bvalid off for n cycles, checking the blocked dcache
  // read never reaches memory, then complete the write and expect the read
  // to be granted in the very next cycle.
  task automatic resp_then_read(input string tag, input int n, input logic [31:0] ret_base);
    logic ok, is_dc;
    logic [31:0] a;
    int waited;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_g);
      check({tag, "_rd_blocked"}, {163'b0, bus.mem_rd_req}, 164'd0);
      check({tag, "_wr_rdy_busy"}, {163'b0, bus.dc_wr_rdy}, 164'd0);
      step();
    end
    bus.mem_wr_bvalid = 1'b1;
    @(negedge clk_g);
    check({tag, "_rd_blocked_bvalid"}, {163'b0, bus.mem_rd_req}, 164'd0);
    step();
    bus.mem_wr_bvalid = 1'b0;
    wait_rd_hs(ok, is_dc, a, waited);
    check({tag, "_rd_after_bvalid"}, 164'(waited), 164'd0);
    bus.dc_rd_req = 1'b0;
    send_beats(ret_base, 4, 1'b1, -1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic ok, is_dc;
    logic [31:0] a;
    int waited, ic_idx, dc_idx;

    resetn = 1'b0;
    bus.ic_rd_req = 0; bus.ic_rd_type = '0; bus.ic_rd_addr = '0;
    bus.dc_rd_req = 0; bus.dc_rd_type = '0; bus.dc_rd_addr = '0;
    bus.dc_wr_req = 0; bus.dc_wr_type = '0; bus.dc_wr_addr = '0;
    bus.dc_wr_wstrb = '0; bus.dc_wr_data = '0;
    bus.mem_rd_rdy = 1'b1; bus.mem_ret_valid = 0; bus.mem_ret_last = 0; bus.mem_ret_data = '0;
    bus.mem_wr_rdy = 1'b1; bus.mem_wr_bvalid = 0;

    // T0: reset values
    repeat (2) @(posedge clk_g);
    @(negedge clk_g);
    check("rst_dc_wr_rdy",    {163'b0, bus.dc_wr_rdy},    164'd1);
    check("rst_ic_rd_rdy",    {163'b0, bus.ic_rd_rdy},    164'd0);
    check("rst_dc_rd_rdy",    {163'b0, bus.dc_rd_rdy},    164'd0);
    check("rst_mem_rd_req",   {163'b0, bus.mem_rd_req},   164'd0);
    check("rst_mem_wr_req",   {163'b0, bus.mem_wr_req},   164'd0);
    check("rst_ret_valid",    {162'b0, bus.ic_ret_valid, bus.dc_ret_valid}, 164'd0);
    check("rst_ret_last",     {162'b0, bus.ic_ret_last, bus.dc_ret_last},   164'd0);
    check("rst_mem_rd_addr",  {132'b0, bus.mem_rd_addr},  164'd0);
    check("rst_mem_wr_addr",  {132'b0, bus.mem_wr_addr},  164'd0);
    check("rst_mem_wr_data",  {36'b0, bus.mem_wr_data},   164'd0);
    step();
    resetn = 1'b1;
    step();

    // T1: single icache line refill
    rd_exp_q.push_back({1'b0, RD_TYPE_LINE, 32'h1C00_0040});
    push_line(1'b0, 32'hA0);
    bus.ic_rd_req = 1; bus.ic_rd_type = RD_TYPE_LINE; bus.ic_rd_addr = 32'h1C00_0040;
    wait_rd_hs(ok, is_dc, a, waited);
    bus.ic_rd_req = 0;
    send_beats(32'hA0, 4, 1'b1, -1);
    step();

    // T2: both caches request three lines each; grants alternate dc, ic, ...
    for (int k = 0; k < 3; k++) begin
      rd_exp_q.push_back({1'b1, RD_TYPE_LINE, 32'h0000_0800 + 32'(k * 16)});
      rd_exp_q.push_back({1'b0, RD_TYPE_LINE, 32'h0000_0100 + 32'(k * 16)});
      push_line(1'b1, 32'hB0B0_0800 + 32'(k * 16));
      push_line(1'b0, 32'hB0B0_0100 + 32'(k * 16));
    end
    ic_idx = 0; dc_idx = 0;
    bus.ic_rd_req = 1; bus.ic_rd_type = RD_TYPE_LINE; bus.ic_rd_addr = 32'h0000_0100;
    bus.dc_rd_req = 1; bus.dc_rd_type = RD_TYPE_LINE; bus.dc_rd_addr = 32'h0000_0800;
    for (int g = 0; g < 6; g++) begin
      wait_rd_hs(ok, is_dc, a, waited);
      if (!ok) break;
      if (is_dc) begin
        dc_idx++;
        if (dc_idx == 3) bus.dc_rd_req = 0;
        else bus.dc_rd_addr = 32'h0000_0800 + 32'(dc_idx * 16);
      end else begin
        ic_idx++;
        if (ic_idx == 3) bus.ic_rd_req = 0;
        else bus.ic_rd_addr = 32'h0000_0100 + 32'(ic_idx * 16);
      end
      send_beats({16'hB0B0, a[15:0]}, 4, 1'b1, -1);
    end
    bus.ic_rd_req = 0; bus.dc_rd_req = 0;
    step();

    // T3: write-back to 0x1230 with delayed bvalid blocks a read of that line
    wr_exp_q.push_back({32'h0000_1230, 4'hF, 128'h1111_2222_3333_4444_5555_6666_7777_8888});
    rd_exp_q.push_back({1'b1, RD_TYPE_LINE, 32'h0000_1230});
    push_line(1'b1, 32'hC0);
    start_write(32'h0000_1230, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    @(negedge clk_g);
    check("t3_wr_rdy_idle", {163'b0, bus.dc_wr_rdy}, 164'd1);
    step();
    bus.dc_wr_req = 0;
    bus.dc_rd_req = 1; bus.dc_rd_type = RD_TYPE_LINE; bus.dc_rd_addr = 32'h0000_1230;
    @(negedge clk_g);
    check("t3_wr_rdy_wreq", {163'b0, bus.dc_wr_rdy}, 164'd0);
    check("t3_rd_blocked_wreq", {163'b0, bus.mem_rd_req}, 164'd0);
    step();
    resp_then_read("t3", 10, 32'hC0);
    step();

    // T4: write to 0x2000 outstanding while icache reads 0x3000
    wr_exp_q.push_back({32'h0000_2000, 4'hF, 128'hDEAD_BEEF});
    rd_exp_q.push_back({1'b0, RD_TYPE_LINE, 32'h0000_3000});
    push_line(1'b0, 32'hE0);
    start_write(32'h0000_2000, 128'hDEAD_BEEF);
    step();
    bus.dc_wr_req = 0;
    bus.ic_rd_req = 1; bus.ic_rd_type = RD_TYPE_LINE; bus.ic_rd_addr = 32'h0000_3000;
    wait_rd_hs(ok, is_dc, a, waited);
    check("t4_rd_immediate", 164'(waited), 164'd0);
    bus.ic_rd_req = 0;
    @(negedge clk_g);
    check("t4_overlap", {162'b0, rd_state_dbg, wr_state_dbg}, {162'b0, R_WAIT_RET, W_RESP});
    step();
    send_beats(32'hE0, 4, 1'b1, 1);
    @(negedge clk_g);
    check("t4_wr_done", {163'b0, bus.dc_wr_rdy}, 164'd1);
    step();

    // T5: write and read of 0x4450 in the same cycle
    wr_exp_q.push_back({32'h0000_4450, 4'hF, 128'h4450});
    rd_exp_q.push_back({1'b1, RD_TYPE_LINE, 32'h0000_4450});
    push_line(1'b1, 32'h4450_0000);
    start_write(32'h0000_4450, 128'h4450);
    bus.dc_rd_req = 1; bus.dc_rd_type = RD_TYPE_LINE; bus.dc_rd_addr = 32'h0000_4450;
    @(negedge clk_g);
    check("t5_same_cycle_block", {163'b0, bus.mem_rd_req}, 164'd0);
    check("t5_wr_accept", {163'b0, bus.dc_wr_rdy}, 164'd1);
    step();
    bus.dc_wr_req = 0;
    @(negedge clk_g);
    check("t5_rd_blocked_wreq", {163'b0, bus.mem_rd_req}, 164'd0);
    step();
    resp_then_read("t5", 3, 32'h4450_0000);
    step();

    // T6: reset in the middle of a refill, then a clean refill
    rd_exp_q.push_back({1'b0, RD_TYPE_LINE, 32'h0000_5000});
    ic_exp_q.push_back({1'b0, 32'h50});
    ic_exp_q.push_back({1'b0, 32'h51});
    bus.ic_rd_req = 1; bus.ic_rd_type = RD_TYPE_LINE; bus.ic_rd_addr = 32'h0000_5000;
    wait_rd_hs(ok, is_dc, a, waited);
    bus.ic_rd_req = 0;
    send_beats(32'h50, 2, 1'b0, -1);
    bus.mem_ret_valid = 1'b1; bus.mem_ret_data = 32'h52;
    resetn = 1'b0;
    #1;
    check("t6_rst_ic_valid", {163'b0, bus.ic_ret_valid}, 164'd0);
    check("t6_rst_ic_data",  {132'b0, bus.ic_ret_data},  164'd0);
    check("t6_rst_rd_state", {163'b0, rd_state_dbg},     {163'b0, R_IDLE});
    check("t6_rst_wr_rdy",   {163'b0, bus.dc_wr_rdy},    164'd1);
    bus.mem_ret_valid = 1'b0; bus.mem_ret_data = '0;
    step();
    resetn = 1'b1;
    step();
    rd_exp_q.push_back({1'b0, RD_TYPE_LINE, 32'h0000_6000});
    push_line(1'b0, 32'h60);
    bus.ic_rd_req = 1; bus.ic_rd_type = RD_TYPE_LINE; bus.ic_rd_addr = 32'h0000_6000;
    wait_rd_hs(ok, is_dc, a, waited);
    check("t6_fresh_grant", 164'(waited), 164'd0);
    bus.ic_rd_req = 0;
    send_beats(32'h60, 4, 1'b1, -1);
    repeat (3) step();

    // ---------------- final report ----------------
    check("rd_q_drained", 164'(rd_exp_q.size()), 164'd0);
    check("ic_q_drained", 164'(ic_exp_q.size()), 164'd0);
    check("dc_q_drained", 164'(dc_exp_q.size()), 164'd0);
    check("wr_q_drained", 164'(wr_exp_q.size()), 164'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
